dac_mem_loader: RTL and testbench
=================================

// Module: dac_mem_loader
// PURPOSE
// - Fills the DAC sample BRAM through port A, ahead of the continuous DAC generator that reads port B.
// - Accepts packed two-channel 32-bit words on a valid/ready stream from the CPU/DMA side.
// - Converts each word to a dac_sample_t (optional signed->offset-binary) and writes LEN consecutive addresses from 0.
// - Reports busy/done/error for CSR readback.
// PARAMETERS
// - ADDR_WIDTH  11  BRAM address width; same value as the DAC generator's.
// PORTS
// - clk          in   1           system clock (65 MHz)
// - rst_n        in   1           reset, synchronous, active-low
// - load_start_i in   1           1-cycle pulse: arm a load of load_len_i words
// - load_abort_i in   1           1-cycle pulse: abandon the load in progress
// - load_len_i   in   ADDR_WIDTH  words to load; sampled on an accepted start
// - fmt_signed_i in   1           1: input is 16-bit two's complement; 0: raw 14-bit; sampled on start
// - dac_en_i     in   1           generator enable (CSR); loading is forbidden while it is 1
// - s_valid_i    in   1           input word valid
// - s_ready_o    out  1           input word ready
// - s_data_i     in   32          [15:0] = ch0, [31:16] = ch1
// - mem_addr_o   out  ADDR_WIDTH  port A write address
// - mem_we_o     out  1           port A write enable
// - mem_wdata_o  out  28          dac_sample_t write data (fields dac_ch0, dac_ch1)
// - busy_o       out  1           state == LOAD
// - done_o       out  1           state == DONE
// - err_o        out  1           sticky: a start was rejected
// - wr_cnt_o     out  ADDR_WIDTH  words written in the current or last load
// BEHAVIOUR
// - Reset: every output is 0, state = IDLE, internal count = 0.
// - FSM has 3 states: IDLE, LOAD, DONE.
// - Accepted start: load_start_i=1 while state is IDLE or DONE, load_len_i != 0 and dac_en_i == 0.
//   - Enters LOAD; latches len and fmt; clears count, wr_cnt_o and err_o.
// - Rejected start (len == 0 or dac_en_i == 1): sets err_o; state and wr_cnt_o are unchanged.
// - load_start_i while in LOAD is ignored and does not set err_o.
// - s_ready_o = (state == LOAD). A handshake occurs on s_valid_i & s_ready_o.
// - Write latency is 1 cycle. The cycle after a handshake:
//   - mem_we_o = 1 and mem_addr_o = count;
//   - mem_wdata_o holds the converted word;
//   - count and wr_cnt_o increment.
// - mem_we_o = 0 on every cycle without a preceding handshake.
// - mem_addr_o and mem_wdata_o hold their last values when mem_we_o = 0.
// - Addresses are strictly sequential 0..len-1, with no wrap-around and no holes, regardless of valid gaps.
// - The handshake that completes the len-th word moves LOAD -> DONE.
//   - done_o rises on the same cycle as the final mem_we_o.
//   - s_ready_o drops on that cycle.
// - DONE holds until an accepted start or reset. load_abort_i in DONE or IDLE has no effect.
// - Abort in LOAD: next state is IDLE, s_ready_o drops the next cycle, done_o stays 0.
//   - A write registered from a handshake on the abort cycle still completes.
// - Start and abort on the same cycle: abort wins, and the start is ignored without an error.
// - dac_en_i rising during LOAD does not stop the load; it only blocks new starts.
// - Raw conversion (fmt = 0):
//   - dac_ch0 = s_data_i[13:0], dac_ch1 = s_data_i[29:16].
//   - Bits [15:14] and [31:30] are ignored.
// - Signed conversion (fmt = 1), truncating with no rounding:
//   - dac_ch0 = {~s_data_i[15], s_data_i[14:2]};
//   - dac_ch1 = {~s_data_i[31], s_data_i[30:18]}.
// - Synchronous reset mid-load returns everything to reset values. BRAM contents are undefined and not cleared.
// TESTING
// - Raw, len=4, words 0x0001_0002 .. 0x0004_0005 back-to-back
//   -> writes at addr 0..3, ch0=2..5, ch1=1..4, done_o=1 with the 4th write, wr_cnt_o=4.
// - Signed, len=3, words 0x8000_7FFF, 0x0000_0000, 0xFFFF_0004
//   -> {ch1,ch0} = {0x0000,0x3FFF}, {0x2000,0x2000}, {0x1FFF,0x2001}.
// - len=6 with s_valid_i toggling randomly
//   -> exactly 6 writes, addresses 0..5 contiguous, mem_we_o=0 in gap cycles.
// - Start with dac_en_i=1, then start with len=0
//   -> err_o=1, s_ready_o stays 0, no writes; a following valid start clears err_o.
// - len=8, abort after 3 handshakes -> 3 writes, IDLE, busy_o=0, done_o=0.
//   Repeat with rst_n=0 mid-load -> all outputs 0 next cycle.
// - len=2047 (maximum) -> last write at addr 2046, done_o=1, wr_cnt_o=2047.
//   A start in DONE restarts at addr 0.

Source files
------------

// File: rtl/dac_mem_loader.sv
// Loads packed two-channel DAC samples into BRAM port A from a valid/ready stream.
// Each word becomes one dac_sample_t, written to consecutive addresses starting at 0.
module dac_mem_loader #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start_i,
    input  logic                  load_abort_i,
    input  logic [ADDR_WIDTH-1:0] load_len_i,
    input  logic                  fmt_signed_i,
    input  logic                  dac_en_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [31:0]           s_data_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [27:0]           mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] wr_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [13:0] dac_ch1;
        logic [13:0] dac_ch0;
    } dac_sample_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_len;
    logic                  r_fmt;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    dac_sample_t           r_wdata;
    logic                  r_err;

    logic                  w_start_req;
    logic                  w_start_acc;
    logic                  w_start_rej;
    logic                  w_hs;
    logic                  w_last;
    dac_sample_t           w_conv;

    // Abort beats a simultaneous start, and a start during LOAD is simply ignored.
    assign w_start_req = load_start_i && !load_abort_i && (r_state != LOAD);
    assign w_start_acc = w_start_req && (load_len_i != '0) && !dac_en_i;
    assign w_start_rej = w_start_req && !w_start_acc;
    assign w_hs        = s_valid_i && s_ready_o;
    assign w_last      = w_hs && (r_count == r_len - ADDR_WIDTH'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_conv = '0;
        if (r_fmt) begin
            w_conv.dac_ch0 = {~s_data_i[15], s_data_i[14:2]};
            w_conv.dac_ch1 = {~s_data_i[31], s_data_i[30:18]};
        end else begin
            w_conv.dac_ch0 = s_data_i[13:0];
            w_conv.dac_ch1 = s_data_i[29:16];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: if (w_start_acc) w_state_nxt = LOAD;
            LOAD: begin
                if (load_abort_i)  w_state_nxt = IDLE;
                else if (w_last)   w_state_nxt = DONE;
            end
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready_o = (r_state == LOAD);
        busy_o    = (r_state == LOAD);
        done_o    = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_fmt   <= 1'b0;
            r_count <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_hs;
            if (w_hs) begin
                r_addr  <= r_count;
                r_wdata <= w_conv;
                r_count <= r_count + ADDR_WIDTH'(1);
            end
            if (w_start_acc) begin
                r_len   <= load_len_i;
                r_fmt   <= fmt_signed_i;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_start_rej) begin
                r_err   <= 1'b1;
            end
        end
    end

    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_wdata_o = r_wdata;
    assign err_o       = r_err;
    assign wr_cnt_o    = r_count;

endmodule

// File: tb/tb_dac_mem_loader.sv
// Directed bench for dac_mem_loader: formats, gaps, start rejection, abort, reset and full length.
module tb_dac_mem_loader;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start_i;
    logic          load_abort_i;
    logic [AW-1:0] load_len_i;
    logic          fmt_signed_i;
    logic          dac_en_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [31:0]   s_data_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [27:0]   mem_wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW-1:0] wr_cnt_o;

    int tests_run  = 0;
    int tests_fail = 0;

    dac_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start_i),
        .load_abort_i (load_abort_i),
        .load_len_i   (load_len_i),
        .fmt_signed_i (fmt_signed_i),
        .dac_en_i     (dac_en_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .wr_cnt_o     (wr_cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW-1:0] len, input logic fmt);
        load_len_i   = len;
        fmt_signed_i = fmt;
        load_start_i = 1'b1;
        step();
        load_start_i = 1'b0;
    endtask

    // {ready, busy, done, err, wr_cnt}
    function automatic logic [AW+3:0] status();
        return {s_ready_o, busy_o, done_o, err_o, wr_cnt_o};
    endfunction

    task automatic test_reset();
        logic [AW+AW+31:0] got;
        rst_n = 1'b0;
        step();
        step();
        got = {s_ready_o, mem_addr_o, mem_we_o, mem_wdata_o, busy_o, done_o, err_o, wr_cnt_o};
        tests_run++;
        if (got !== '0) begin
            tests_fail++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_raw();
        logic [39:0] got, exp;
        start_load(AW'(4), 1'b0);
        tests_run++;
        if (status() !== {1'b1, 1'b1, 1'b0, 1'b0, 11'd0}) begin
            tests_fail++;
            $display("FAIL raw_start_status: got %h expected %h", status(), {1'b1, 1'b1, 1'b0, 1'b0, 11'd0});
        end
        for (int i = 0; i < 4; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = {16'(i + 1), 16'(i + 2)};
            step();
            got = {mem_we_o, mem_addr_o, mem_wdata_o};
            exp = {1'b1, 11'(i), 14'(i + 1), 14'(i + 2)};
            tests_run++;
            if (got !== exp) begin
                tests_fail++;
                $display("FAIL raw_write_%0d: got %h expected %h", i, got, exp);
            end
        end
        tests_run++;
        if (status() !== {1'b0, 1'b0, 1'b1, 1'b0, 11'd4}) begin
            tests_fail++;
            $display("FAIL raw_done_with_last_write: got %h expected %h", status(), {1'b0, 1'b0, 1'b1, 1'b0, 11'd4});
        end
        s_valid_i = 1'b1;
        s_data_i  = 32'hDEAD_BEEF;
        step();
        got = {mem_we_o, mem_addr_o, mem_wdata_o};
        exp = {1'b0, 11'd3, 14'd4, 14'd5};
        tests_run++;
        if (got !== exp || done_o !== 1'b1) begin
            tests_fail++;
            $display("FAIL raw_hold_after_done: got %h done %b expected %h done 1", got, done_o, exp);
        end
        s_valid_i = 1'b0;
        // Bits [15:14] and [31:30] must be dropped in raw mode.
        start_load(AW'(1), 1'b0);
        s_valid_i = 1'b1;
        s_data_i  = 32'hFFFF_C000;
        step();
        s_valid_i = 1'b0;
        got = {mem_we_o, mem_addr_o, mem_wdata_o};
        exp = {1'b1, 11'd0, 14'h3FFF, 14'h0000};
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL raw_upper_bits_ignored: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_signed();
        logic [31:0] din [3];
        logic [27:0] dexp[3];
        logic [39:0] got, exp;
        din[0] = 32'h8000_7FFF; dexp[0] = {14'h0000, 14'h3FFF};
        din[1] = 32'h0000_0000; dexp[1] = {14'h2000, 14'h2000};
        din[2] = 32'hFFFF_0004; dexp[2] = {14'h1FFF, 14'h2001};
        start_load(AW'(3), 1'b1);
        for (int i = 0; i < 3; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = din[i];
            step();
            got = {mem_we_o, mem_addr_o, mem_wdata_o};
            exp = {1'b1, 11'(i), dexp[i]};
            tests_run++;
            if (got !== exp) begin
                tests_fail++;
                $display("FAIL signed_write_%0d: got %h expected %h", i, got, exp);
            end
        end
        s_valid_i = 1'b0;
        tests_run++;
        if (status() !== {1'b0, 1'b0, 1'b1, 1'b0, 11'd3}) begin
            tests_fail++;
            $display("FAIL signed_done: got %h expected %h", status(), {1'b0, 1'b0, 1'b1, 1'b0, 11'd3});
        end
    endtask

    task automatic test_valid_gaps();
        logic [19:0] pat = 20'b0000_1010_0110_0101_1001;
        logic        exp_busy = 1'b1;
        logic        hs;
        int          exp_cnt = 0;
        int          bad = 0;
        start_load(AW'(6), 1'b0);
        for (int k = 0; k < 20; k++) begin
            s_valid_i = pat[k];
            s_data_i  = 32'(k);
            hs = pat[k] && exp_busy;
            step();
            if (mem_we_o !== hs) bad++;
            if (hs) begin
                if (mem_addr_o !== AW'(exp_cnt)) bad++;
                exp_cnt++;
                if (exp_cnt == 6) exp_busy = 1'b0;
            end
            if (s_ready_o !== exp_busy || done_o !== !exp_busy) bad++;
        end
        s_valid_i = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_fail++;
            $display("FAIL gaps_per_cycle: got %0d bad cycles expected 0", bad);
        end
        tests_run++;
        if (exp_cnt != 6 || wr_cnt_o !== AW'(6) || done_o !== 1'b1) begin
            tests_fail++;
            $display("FAIL gaps_total: got wr_cnt %0d done %b expected 6 done 1", wr_cnt_o, done_o);
        end
    endtask

    task automatic test_start_reject();
        int writes = 0;
        dac_en_i = 1'b1;
        start_load(AW'(5), 1'b0);
        tests_run++;
        if (status() !== {1'b0, 1'b0, 1'b1, 1'b1, 11'd6}) begin
            tests_fail++;
            $display("FAIL reject_dac_en: got %h expected %h", status(), {1'b0, 1'b0, 1'b1, 1'b1, 11'd6});
        end
        dac_en_i = 1'b0;
        start_load(AW'(0), 1'b0);
        s_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (mem_we_o !== 1'b0 || s_ready_o !== 1'b0) writes++;
        end
        s_valid_i = 1'b0;
        tests_run++;
        if (writes != 0 || err_o !== 1'b1 || wr_cnt_o !== AW'(6)) begin
            tests_fail++;
            $display("FAIL reject_len_zero: got bad %0d err %b wr_cnt %0d expected 0 1 6", writes, err_o, wr_cnt_o);
        end
        start_load(AW'(2), 1'b0);
        tests_run++;
        if (status() !== {1'b1, 1'b1, 1'b0, 1'b0, 11'd0}) begin
            tests_fail++;
            $display("FAIL reject_then_accept: got %h expected %h", status(), {1'b1, 1'b1, 1'b0, 1'b0, 11'd0});
        end
        s_valid_i = 1'b1;
        s_data_i  = 32'h0;
        step();
        s_valid_i = 1'b0;
        start_load(AW'(0), 1'b0);
        tests_run++;
        if (status() !== {1'b1, 1'b1, 1'b0, 1'b0, 11'd1}) begin
            tests_fail++;
            $display("FAIL start_in_load_ignored: got %h expected %h", status(), {1'b1, 1'b1, 1'b0, 1'b0, 11'd1});
        end
        s_valid_i = 1'b1;
        step();
        s_valid_i = 1'b0;
    endtask

    task automatic test_abort();
        logic [AW+3:0] st;
        start_load(AW'(8), 1'b0);
        dac_en_i  = 1'b1;
        s_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data_i = 32'(i);
            step();
        end
        s_data_i     = 32'h0009_0007;
        load_abort_i = 1'b1;
        step();
        load_abort_i = 1'b0;
        tests_run++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 11'd2, 14'd9, 14'd7}) begin
            tests_fail++;
            $display("FAIL abort_cycle_write: got %h expected %h", {mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 11'd2, 14'd9, 14'd7});
        end
        tests_run++;
        if (status() !== {1'b0, 1'b0, 1'b0, 1'b0, 11'd3}) begin
            tests_fail++;
            $display("FAIL abort_to_idle: got %h expected %h", status(), {1'b0, 1'b0, 1'b0, 1'b0, 11'd3});
        end
        step();
        s_valid_i = 1'b0;
        tests_run++;
        if (mem_we_o !== 1'b0) begin
            tests_fail++;
            $display("FAIL abort_no_more_writes: got %b expected 0", mem_we_o);
        end
        dac_en_i     = 1'b0;
        load_abort_i = 1'b1;
        start_load(AW'(4), 1'b0);
        load_abort_i = 1'b0;
        st = status();
        tests_run++;
        if (st !== {1'b0, 1'b0, 1'b0, 1'b0, 11'd3}) begin
            tests_fail++;
            $display("FAIL start_abort_same_cycle: got %h expected %h", st, {1'b0, 1'b0, 1'b0, 1'b0, 11'd3});
        end
    endtask

    task automatic test_reset_mid_load();
        logic [AW+AW+31:0] got;
        start_load(AW'(8), 1'b1);
        s_valid_i = 1'b1;
        s_data_i  = 32'h1234_5678;
        step();
        step();
        rst_n = 1'b0;
        step();
        got = {s_ready_o, mem_addr_o, mem_we_o, mem_wdata_o, busy_o, done_o, err_o, wr_cnt_o};
        tests_run++;
        if (got !== '0) begin
            tests_fail++;
            $display("FAIL reset_mid_load: got %h expected 0", got);
        end
        rst_n     = 1'b1;
        s_valid_i = 1'b0;
        step();
    endtask

    task automatic test_max_len();
        int bad = 0;
        start_load(AW'(2047), 1'b0);
        s_valid_i = 1'b1;
        for (int i = 0; i < 2047; i++) begin
            s_data_i = 32'(i);
            step();
            if (mem_we_o !== 1'b1 || mem_addr_o !== AW'(i)) bad++;
            if ((i < 2046) && (done_o !== 1'b0)) bad++;
        end
        s_valid_i = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_fail++;
            $display("FAIL max_len_sequence: got %0d bad writes expected 0", bad);
        end
        tests_run++;
        if ({mem_addr_o, status()} !== {11'd2046, 1'b0, 1'b0, 1'b1, 1'b0, 11'd2047}) begin
            tests_fail++;
            $display("FAIL max_len_end: got %h expected %h", {mem_addr_o, status()}, {11'd2046, 1'b0, 1'b0, 1'b1, 1'b0, 11'd2047});
        end
        start_load(AW'(2), 1'b0);
        s_valid_i = 1'b1;
        s_data_i  = 32'h0;
        step();
        s_valid_i = 1'b0;
        tests_run++;
        if ({mem_we_o, mem_addr_o, wr_cnt_o} !== {1'b1, 11'd0, 11'd1}) begin
            tests_fail++;
            $display("FAIL restart_from_done: got %h expected %h", {mem_we_o, mem_addr_o, wr_cnt_o}, {1'b1, 11'd0, 11'd1});
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start_i = 1'b0;
        load_abort_i = 1'b0;
        load_len_i   = '0;
        fmt_signed_i = 1'b0;
        dac_en_i     = 1'b0;
        s_valid_i    = 1'b0;
        s_data_i     = '0;
        test_reset();
        test_raw();
        test_signed();
        test_valid_gaps();
        test_start_reject();
        test_abort();
        test_reset_mid_load();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
